cnn_bn_relu_16x16: RTL and testbench

- Per-channel affine (folded batch-norm scale and bias) followed by ReLU.
- Sits directly downstream of the 3x3 atrous conv stage and consumes its aligned pxl_out/valid_out stream.
- Input order is channel-major: IMAGE_SIZE consecutive pixels of output channel 0, then channel 1, and so on up to CHANNEL_NUM_OUT-1.
- Coefficients are loaded serially once after reset, into internal RAM.

---
 rtl/cnn_bn_relu_16x16_pkg.sv | 27 ++
 rtl/cnn_bn_relu_16x16_bn_coef_ram.sv | 36 +++
 rtl/cnn_bn_relu_16x16.sv | 175 +++++++++++++++++
 tb/tb_cnn_bn_relu_16x16.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/cnn_bn_relu_16x16_pkg.sv
// Shared constants and helpers for the folded batch-norm + ReLU stage.
// The defaults describe the 16x16 feature map with 512 output channels.
// The top level re-derives every width from its own parameters, so a
// smaller instance (for example, fewer channels) stays self-consistent.
package cnn_bn_relu_16x16_pkg;

  localparam int DEF_DATA_WIDTH      = 16;
  localparam int DEF_FRAC_BITS       = 8;
  localparam int DEF_IMAGE_WIDTH     = 16;
  localparam int DEF_IMAGE_HEIGHT    = 16;
  localparam int DEF_IMAGE_SIZE      = DEF_IMAGE_WIDTH * DEF_IMAGE_HEIGHT;
  localparam int DEF_CHANNEL_NUM_OUT = 512;

  // Counter width helper. A one-entry counter still needs a 1-bit register.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int CNT_WIDTH_PIXEL    = cnt_w(DEF_IMAGE_SIZE);
  localparam int CNT_WIDTH_CH       = cnt_w(DEF_CHANNEL_NUM_OUT);
  localparam int POINTER_WIDTH_COEF = cnt_w(2 * DEF_CHANNEL_NUM_OUT);

  // Output clamp limits for the default sample width.
  localparam logic signed [DEF_DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DEF_DATA_WIDTH-1){1'b1}}};
  localparam logic signed [DEF_DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DEF_DATA_WIDTH-1){1'b0}}};

endpackage

// File: rtl/cnn_bn_relu_16x16_bn_coef_ram.sv
// bn_coef_ram: simple dual-port coefficient RAM.
// This RAM has one write port and one read port. The read data is
// registered, so it arrives one cycle after raddr is presented.
// There is no reset on the array. This lets the tools map it to
// distributed RAM or to a BRAM.
// Ports:
//   clk          clock
//   we/waddr/wdata   write port
//   raddr        read address
//   rdata        read data, 1-cycle latency
module bn_coef_ram
  import cnn_bn_relu_16x16_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 512,
  localparam int AW   = cnt_w(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/cnn_bn_relu_16x16.sv
// cnn_bn_relu_16x16: per-channel affine transform (folded batch-norm scale
// and bias) followed by ReLU. It consumes the channel-major pixel stream
// coming from the atrous conv stage.
// Ports:
//   clk, reset                  clock and synchronous active-high reset
//   valid_in, pxl_in            signed input pixel stream
//   valid_coef_in, coef_in      serial coefficient load, in the order
//                               scale0, bias0, scale1, bias1, ...
//   pxl_out, valid_out          activated pixel, 3 cycles after acceptance
//   coef_ready                  all coefficients have been loaded
//   frame_done                  pulses with the last pixel of the last channel
module cnn_bn_relu_16x16
  import cnn_bn_relu_16x16_pkg::*;
#(
  parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int FRAC_BITS       = DEF_FRAC_BITS,
  parameter int IMAGE_WIDTH     = DEF_IMAGE_WIDTH,
  parameter int IMAGE_HEIGHT    = DEF_IMAGE_HEIGHT,
  parameter int CHANNEL_NUM_OUT = DEF_CHANNEL_NUM_OUT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] pxl_in,
  input  logic                  valid_coef_in,
  input  logic [DATA_WIDTH-1:0] coef_in,
  output logic [DATA_WIDTH-1:0] pxl_out,
  output logic                  valid_out,
  output logic                  coef_ready,
  output logic                  frame_done
);

  localparam int IMAGE_SIZE = IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam int STAGES     = 3;
  localparam int PIX_W      = cnt_w(IMAGE_SIZE);
  localparam int CH_W       = cnt_w(CHANNEL_NUM_OUT);
  localparam int PTR_W      = CH_W + 1;          // LSB selects scale/bias
  localparam int PROD_W     = 2 * DATA_WIDTH;
  localparam int SUM_W      = PROD_W + 1;        // one guard bit for the bias add

  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(IMAGE_SIZE - 1);
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(CHANNEL_NUM_OUT - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(2 * CHANNEL_NUM_OUT - 1);

  localparam logic signed [PROD_W-1:0] ROUND =
    {{(PROD_W-FRAC_BITS){1'b0}}, 1'b1, {(FRAC_BITS-1){1'b0}}};
  localparam logic signed [SUM_W-1:0] SUM_MAX =
    {{(SUM_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] SUM_MIN =
    {{(SUM_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  // Control state
  logic [PTR_W-1:0]      coef_ptr_q, coef_ptr_d;
  logic                  coef_ready_q, coef_ready_d;
  logic [PIX_W-1:0]      pix_cnt_q, pix_cnt_d;
  logic [CH_W-1:0]       ch_cnt_q, ch_cnt_d;
  logic [STAGES:1]       vld_pipe_q, vld_pipe_d;
  logic [STAGES:1]       last_pipe_q, last_pipe_d;
  logic [DATA_WIDTH-1:0] pxl_out_q, pxl_out_d;

  // Datapath registers
  logic signed [DATA_WIDTH-1:0] pix_s1_q, pix_s1_d;
  logic signed [PROD_W-1:0]     sh_s2_q, sh_s2_d;
  logic [DATA_WIDTH-1:0]        bias_s2_q, bias_s2_d;

  logic                         coef_we, accept, pix_last;
  logic [1:0]                   bank_we;
  logic [1:0][DATA_WIDTH-1:0]   coef_rd;   // [0] scale, [1] bias
  logic signed [PROD_W-1:0]     prod, rnd;
  logic signed [SUM_W-1:0]      sum;
  logic [DATA_WIDTH-1:0]        sat, relu;

  // The scale and bias words are split over two banks by address LSB.
  // Together they hold 2*CHANNEL_NUM_OUT words. Both words of a channel
  // are read in the same cycle, using ch_cnt at acceptance time.
  assign bank_we = {coef_we & coef_ptr_q[0], coef_we & ~coef_ptr_q[0]};

  for (genvar b = 0; b < 2; b++) begin : g_bank
    bn_coef_ram #(
      .WIDTH (DATA_WIDTH),
      .DEPTH (CHANNEL_NUM_OUT)
    ) u_ram (
      .clk   (clk),
      .we    (bank_we[b]),
      .waddr (coef_ptr_q[PTR_W-1:1]),
      .wdata (coef_in),
      .raddr (ch_cnt_q),
      .rdata (coef_rd[b])
    );
  end

  always_comb begin
    coef_ptr_d   = coef_ptr_q;
    coef_ready_d = coef_ready_q;
    pix_cnt_d    = pix_cnt_q;
    ch_cnt_d     = ch_cnt_q;

    // Once coef_ready is set, further words are ignored.
    coef_we = valid_coef_in & ~coef_ready_q;
    if (coef_we) begin
      coef_ptr_d = coef_ptr_q + PTR_W'(1);
      if (coef_ptr_q == PTR_LAST) coef_ready_d = 1'b1;
    end

    // A pixel that arrives together with the final coefficient is still
    // dropped, because the registered coef_ready is low in that cycle.
    accept   = valid_in & coef_ready_q;
    pix_last = (pix_cnt_q == PIX_LAST);
    if (accept) begin
      if (pix_last) begin
        pix_cnt_d = '0;
        ch_cnt_d  = (ch_cnt_q == CH_LAST) ? '0 : ch_cnt_q + CH_W'(1);
      end else begin
        pix_cnt_d = pix_cnt_q + PIX_W'(1);
      end
    end

    vld_pipe_d  = {vld_pipe_q[STAGES-1:1], accept};
    last_pipe_d = {last_pipe_q[STAGES-1:1], accept & pix_last & (ch_cnt_q == CH_LAST)};

    // S1: register the pixel. The coefficient read is in flight.
    pix_s1_d = pxl_in;

    // S2: full-width product, then round half up and shift to the pixel format.
    prod      = $signed({{DATA_WIDTH{pix_s1_q[DATA_WIDTH-1]}}, pix_s1_q})
              * $signed({{DATA_WIDTH{coef_rd[0][DATA_WIDTH-1]}}, coef_rd[0]});
    rnd       = prod + ROUND;
    sh_s2_d   = rnd >>> FRAC_BITS;
    bias_s2_d = coef_rd[1];

    // S3: add the bias with a guard bit, saturate, then apply ReLU.
    sum = $signed({sh_s2_q[PROD_W-1], sh_s2_q})
        + $signed({{(SUM_W-DATA_WIDTH){bias_s2_q[DATA_WIDTH-1]}}, bias_s2_q});
    if (sum > SUM_MAX)      sat = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    else if (sum < SUM_MIN) sat = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    else                    sat = sum[DATA_WIDTH-1:0];
    relu = sat[DATA_WIDTH-1] ? '0 : sat;

    // Hold the last result through gaps in the stream.
    pxl_out_d = vld_pipe_q[STAGES-1] ? relu : pxl_out_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      coef_ptr_q   <= '0;
      coef_ready_q <= 1'b0;
      pix_cnt_q    <= '0;
      ch_cnt_q     <= '0;
      vld_pipe_q   <= '0;
      last_pipe_q  <= '0;
      pxl_out_q    <= '0;
    end else begin
      coef_ptr_q   <= coef_ptr_d;
      coef_ready_q <= coef_ready_d;
      pix_cnt_q    <= pix_cnt_d;
      ch_cnt_q     <= ch_cnt_d;
      vld_pipe_q   <= vld_pipe_d;
      last_pipe_q  <= last_pipe_d;
      pxl_out_q    <= pxl_out_d;
    end
  end

  // Datapath registers are qualified by vld_pipe, so they need no reset.
  always_ff @(posedge clk) begin
    pix_s1_q  <= pix_s1_d;
    sh_s2_q   <= sh_s2_d;
    bias_s2_q <= bias_s2_d;
  end

  assign pxl_out    = pxl_out_q;
  assign valid_out  = vld_pipe_q[STAGES];
  assign frame_done = last_pipe_q[STAGES];
  assign coef_ready = coef_ready_q;

endmodule

// File: tb/tb_cnn_bn_relu_16x16.sv
module tb_cnn_bn_relu_16x16;

  localparam int CH  = 4;
  localparam int IMG = 256;

  logic        clk, reset, valid_in, valid_coef_in;
  logic [15:0] pxl_in, coef_in, pxl_out;
  logic        valid_out, coef_ready, frame_done;

  cnn_bn_relu_16x16 #(.CHANNEL_NUM_OUT(CH)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .pxl_in(pxl_in),
    .valid_coef_in(valid_coef_in), .coef_in(coef_in), .pxl_out(pxl_out),
    .valid_out(valid_out), .coef_ready(coef_ready), .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [15:0] scale, bias, pix, exp; } tv_t;
  typedef struct { int due; logic [15:0] val; logic last; } exp_t;

  tv_t         tv [12];
  exp_t        q [$];
  logic [15:0] sc [CH], bi [CH], ld_s [CH], ld_b [CH];
  logic [15:0] last_out;
  logic        m_ready;
  int          m_ptr, m_pc, m_ch, cyc, n_chk, n_pass, n_fd, sent;

  // Reference model: (pixel*scale) rounded half up at 2^-8, plus bias, clamped, then ReLU.
  function automatic logic [15:0] ref_bn(input logic [15:0] p, input logic [15:0] s,
                                         input logic [15:0] b);
    longint pv, sv, bv, r;
    pv = $signed(p); sv = $signed(s); bv = $signed(b);
    r = ((pv * sv) + 128) >>> 8;
    r = r + bv;
    if (r > 32767) r = 32767;
    if (r < 0) r = 0;
    return r[15:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Each call covers one clock. It drives the inputs, updates the model at
  // the edge, and checks the outputs on the falling edge.
  task automatic step(input logic vi, input logic [15:0] px, input logic vc,
                      input logic [15:0] cw, input logic rst);
    exp_t e;
    valid_in = vi; pxl_in = px; valid_coef_in = vc; coef_in = cw; reset = rst;
    @(posedge clk);
    cyc++;
    if (rst) begin
      q.delete(); m_ready = 0; m_ptr = 0; m_pc = 0; m_ch = 0; last_out = 16'h0;
    end else begin
      if (vi && m_ready) begin
        e.due  = cyc + 2;
        e.val  = ref_bn(px, sc[m_ch], bi[m_ch]);
        e.last = (m_pc == IMG-1) && (m_ch == CH-1);
        q.push_back(e);
        if (m_pc == IMG-1) begin m_pc = 0; m_ch = (m_ch + 1) % CH; end
        else m_pc++;
      end
      if (vc && !m_ready) begin
        if (m_ptr % 2 == 0) sc[m_ptr/2] = cw; else bi[m_ptr/2] = cw;
        if (m_ptr == 2*CH-1) m_ready = 1;
        m_ptr++;
      end
    end
    @(negedge clk);
    if (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      chk("valid_out", 32'(valid_out), 32'(1'b1));
      chk("pxl_out", 32'(pxl_out), 32'(e.val));
      chk("frame_done", 32'(frame_done), 32'(e.last));
      last_out = e.val;
    end else begin
      chk("valid_out_idle", 32'(valid_out), 32'(1'b0));
      chk("pxl_out_hold", 32'(pxl_out), 32'(last_out));
      chk("frame_done_idle", 32'(frame_done), 32'(1'b0));
    end
    if (frame_done) n_fd++;
    chk("coef_ready", 32'(coef_ready), 32'(m_ready));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b0, 16'h0, 1'b0, 16'h0, 1'b1);
  endtask

  task automatic load_coefs(input logic vi);
    for (int i = 0; i < 2*CH; i++)
      step(vi, 16'h0100, 1'b1, (i % 2) ? ld_b[i/2] : ld_s[i/2], 1'b0);
  endtask

  task automatic rand_coefs();
    for (int c = 0; c < CH; c++) begin
      ld_s[c] = 16'($urandom_range(0, 1023)) - 16'd512;
      ld_b[c] = 16'($urandom_range(0, 4095)) - 16'd2048;
    end
  endtask

  initial begin
    // scale, bias, pixel -> expected output
    tv[0]  = '{16'h0100, 16'h0000, 16'h0100, 16'h0100};
    tv[1]  = '{16'h0100, 16'h0000, 16'h0A80, 16'h0A80};
    tv[2]  = '{16'h0100, 16'h0000, 16'hFF00, 16'h0000};
    tv[3]  = '{16'h0080, 16'h0040, 16'h0003, 16'h0042};
    tv[4]  = '{16'h0200, 16'h0000, 16'h7000, 16'h7FFF};
    tv[5]  = '{16'h0200, 16'h0000, 16'h9000, 16'h0000};
    tv[6]  = '{16'hFF00, 16'h0100, 16'h0080, 16'h0080};
    tv[7]  = '{16'h0080, 16'h0010, 16'hFFFD, 16'h000F};
    tv[8]  = '{16'h0100, 16'h7F00, 16'h7F00, 16'h7FFF};
    tv[9]  = '{16'h0080, 16'h0000, 16'h0001, 16'h0001};
    tv[10] = '{16'h0080, 16'h0005, 16'hFFFF, 16'h0005};
    tv[11] = '{16'h8000, 16'h8000, 16'h8000, 16'h7FFF};

    n_chk = 0; n_pass = 0; n_fd = 0; cyc = 0; sent = 0;
    m_ready = 0; m_ptr = 0; m_pc = 0; m_ch = 0; last_out = 16'h0;
    for (int c = 0; c < CH; c++) begin sc[c] = 16'h0; bi[c] = 16'h0; end
    valid_in = 0; pxl_in = 0; valid_coef_in = 0; coef_in = 0; reset = 1;

    // Check the reset state.
    do_reset(); do_reset();
    chk("rst_pxl_out", 32'(pxl_out), 32'h0);
    chk("rst_valid_out", 32'(valid_out), 32'h0);
    chk("rst_coef_ready", 32'(coef_ready), 32'h0);
    chk("rst_frame_done", 32'(frame_done), 32'h0);

    // Apply the table vectors. Each one reloads all channels with one scale/bias pair.
    for (int i = 0; i < 12; i++) begin
      do_reset();
      for (int c = 0; c < CH; c++) begin ld_s[c] = tv[i].scale; ld_b[c] = tv[i].bias; end
      load_coefs(1'b0);
      step(1'b1, tv[i].pix, 1'b0, 16'h0, 1'b0);
      idle(2);
      chk($sformatf("tv%0d_valid", i), 32'(valid_out), 32'h1);
      chk($sformatf("tv%0d_pxl", i), 32'(pxl_out), 32'(tv[i].exp));
      idle(1);
    end

    // Load gating: pixels before the load and during it (including the
    // final word) are dropped, and extra coefficients are ignored.
    do_reset();
    step(1'b1, 16'h0100, 1'b0, 16'h0, 1'b0);
    step(1'b1, 16'h0100, 1'b0, 16'h0, 1'b0);
    for (int c = 0; c < CH; c++) begin ld_s[c] = 16'h0100; ld_b[c] = 16'(16 * (c + 1)); end
    load_coefs(1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 16'h0, 1'b1, 16'h1234, 1'b0);
    step(1'b1, 16'h0100, 1'b0, 16'h0, 1'b0);
    idle(2);
    chk("gate_first_pxl", 32'(pxl_out), 32'h0110);
    idle(1);

    // Channel boundary: the 257th zero pixel picks up the ch1 bias.
    do_reset();
    for (int c = 0; c < CH; c++) begin ld_s[c] = 16'h0100; ld_b[c] = 16'(c * 256); end
    load_coefs(1'b0);
    for (int i = 0; i < IMG + 1; i++) step(1'b1, 16'h0, 1'b0, 16'h0, 1'b0);
    idle(3);
    chk("ch_boundary_257", 32'(pxl_out), 32'h0100);

    // Full random frame with gaps, then a little of the next frame.
    do_reset();
    rand_coefs();
    load_coefs(1'b0);
    n_fd = 0; sent = 0;
    while (sent < CH*IMG + 20) begin
      if ($urandom_range(3) != 0) begin
        step(1'b1, 16'($urandom), 1'b0, 16'h0, 1'b0); sent++;
      end else step(1'b0, 16'($urandom), 1'b0, 16'h0, 1'b0);
    end
    idle(4);
    chk("frame_done_count", 32'(n_fd), 32'h1);

    // Mid-frame reset at ch3 pixel 100, with the pipeline full.
    do_reset();
    rand_coefs();
    load_coefs(1'b0);
    for (int i = 0; i < 3*IMG + 101; i++) step(1'b1, 16'($urandom), 1'b0, 16'h0, 1'b0);
    step(1'b1, 16'h0055, 1'b0, 16'h0, 1'b1);
    chk("midrst_valid_out", 32'(valid_out), 32'h0);
    chk("midrst_coef_ready", 32'(coef_ready), 32'h0);
    idle(3);
    rand_coefs();
    load_coefs(1'b0);
    step(1'b1, 16'h0234, 1'b0, 16'h0, 1'b0);
    idle(2);
    chk("midrst_ch0_pxl", 32'(pxl_out), 32'(ref_bn(16'h0234, ld_s[0], ld_b[0])));
    idle(2);
    chk("queue_drained", 32'(q.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
